// File: rtl/ev21g1_pkg.sv
// Shared default widths/reset address and the fetch-entry layout for the ev21g1 fetch slice.
package ev21g1_pkg;
    localparam int EV21G1_ADDR_W   = 10;
    localparam int EV21G1_INSTR_W  = 32;
    localparam int EV21G1_RESET_PC = 0;

    typedef struct packed {
        logic [EV21G1_INSTR_W-1:0] instr;
        logic [EV21G1_ADDR_W-1:0]  pc;
    } fetch_entry_t;
endpackage

// File: rtl/ev21g1_fetch_fifo.sv
// Two-entry instruction buffer; push lands at the edge, head visible next cycle.
// Push is dropped when full unless a pop frees a slot that cycle; flush empties at the edge.
module ev21g1_fetch_fifo
    import ev21g1_pkg::*;
#(
    parameter int W = $bits(fetch_entry_t)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign do_pop  = pop_i & (count_q != 2'd0);
    assign do_push = push_i & ((count_q != 2'd2) | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/ev21g1_ifetch.sv
// Instruction fetch: one-cycle program memory, 2-entry buffer, first instr 2 cycles after first read.
// Reads throttle so buffered + in-flight never exceeds 2; redirect flushes via epoch tagging.
module ev21g1_ifetch
    import ev21g1_pkg::*;
#(
    parameter int                ADDR_W   = EV21G1_ADDR_W,
    parameter int                INSTR_W  = EV21G1_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(EV21G1_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pm_rd,
    output logic [ADDR_W-1:0]  pm_addr,
    input  logic [INSTR_W-1:0] pm_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic              run_q;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              epoch_q, epoch_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] infl_pc_q;
    logic              infl_epoch_q;

    logic               pop, push;
    logic               fifo_full, fifo_empty;
    logic [1:0]         fifo_count;
    logic [2:0]         occupancy;
    entry_t             push_entry, head;
    logic [ENTRY_W-1:0] head_bits;

    assign pop       = instr_valid & instr_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign pm_rd     = run_q & ~redirect & (occupancy < 3'd2);
    assign pm_addr   = fetch_pc_q;

    // A response whose epoch predates the latest redirect belongs to the flushed path.
    assign push       = inflight_q & (infl_epoch_q == epoch_q) & (~fifo_full | pop);
    assign push_entry = '{instr: pm_data, pc: infl_pc_q};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            epoch_d    = ~epoch_q;
        end else if (pm_rd) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q        <= 1'b0;
            fetch_pc_q   <= RESET_PC;
            epoch_q      <= 1'b0;
            inflight_q   <= 1'b0;
            infl_pc_q    <= '0;
            infl_epoch_q <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
            inflight_q <= pm_rd;
            if (pm_rd) begin
                infl_pc_q    <= fetch_pc_q;
                infl_epoch_q <= epoch_q;
            end
        end
    end

    ev21g1_fetch_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .dout_o  (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head        = head_bits;
    assign instr_valid = ~fifo_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_ev21g1_ifetch.sv
// Bench for ev21g1_ifetch: directed scenarios plus randomized ready/redirect against an in-order PC stream model.
module tb_ev21g1_ifetch;

    localparam int ADDR_W = 10;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 10'd0;

    logic               clk = 1'b0;
    logic               reset;
    logic               pm_rd;
    logic [ADDR_W-1:0]  pm_addr;
    logic [INSTR_W-1:0] pm_data;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;

    ev21g1_ifetch #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pm_rd       (pm_rd),
        .pm_addr     (pm_addr),
        .pm_data     (pm_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;
    int viol;

    // Reference stream: each handshake must deliver the next sequential PC, restarting at a redirect target.
    int                 ref_next;
    int                 ref_pc[$];
    int                 obs_pc[$];
    logic [INSTR_W-1:0] obs_instr[$];

    logic               s_rd, s_valid;
    logic [ADDR_W-1:0]  s_addr, s_pc;
    logic [INSTR_W-1:0] s_instr;
    logic               prev_reset, prev_valid, prev_ready, prev_redirect;
    logic [ADDR_W-1:0]  prev_pc;
    logic [INSTR_W-1:0] prev_instr;

    // One clock cycle: inputs were set at the preceding falling edge; sample, model, then serve memory.
    task automatic advance();
        logic [INSTR_W-1:0] nxt;
        #3;
        s_rd = pm_rd; s_addr = pm_addr; s_valid = instr_valid; s_instr = instr; s_pc = instr_pc;
        if (!reset) begin
            if (pm_rd !== 1'b0 || pm_addr !== RESET_PC || instr_valid !== 1'b0) viol++;
            ref_next = int'(RESET_PC);
        end else begin
            if (redirect && pm_rd !== 1'b0) viol++;
            if (prev_reset && prev_redirect && instr_valid !== 1'b0) viol++;
            if (prev_reset && prev_valid && !prev_ready && !prev_redirect &&
                (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_pc)) viol++;
            if (instr_valid === 1'b1 && instr_ready) begin
                obs_pc.push_back(int'(instr_pc));
                obs_instr.push_back(instr);
                ref_pc.push_back(ref_next);
                ref_next = (ref_next + 1) % 1024;
            end
            if (redirect) ref_next = int'(redirect_pc);
        end
        prev_reset = reset; prev_valid = instr_valid; prev_ready = instr_ready;
        prev_redirect = redirect; prev_pc = instr_pc; prev_instr = instr;
        nxt = (pm_rd === 1'b1) ? (32'h1000 + {22'd0, pm_addr}) : $urandom();
        @(posedge clk);
        #1 pm_data = nxt;
        @(negedge clk);
    endtask

    task automatic restart();
        reset = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        advance();
        advance();
        obs_pc.delete(); obs_instr.delete(); ref_pc.delete();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
        repeat (3) advance();
        checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL reset_pm_rd: got %b want 0", s_rd); end
        checks++; if (s_addr !== RESET_PC) begin errors++; $display("FAIL reset_pm_addr: got %h want %h", s_addr, RESET_PC); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", s_valid); end
        checks++; if (s_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", s_instr); end
        checks++; if (s_pc !== 10'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", s_pc); end
    endtask

    task automatic test_startup();
        int nvalid;
        restart();
        instr_ready = 1'b1;
        advance();
        checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL start_cycle0_rd: got %b want 0", s_rd); end
        advance();
        checks++; if (s_rd !== 1'b1 || s_addr !== 10'h0) begin errors++; $display("FAIL start_cycle1_rd: got rd=%b addr=%h want rd=1 addr=000", s_rd, s_addr); end
        advance();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL start_cycle2_valid: got %b want 0", s_valid); end
        for (int k = 0; k < 3; k++) begin
            advance();
            checks++;
            if (s_valid !== 1'b1 || s_instr !== 32'h1000 + k || s_pc !== 10'(k)) begin
                errors++;
                $display("FAIL start_deliver%0d: got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h",
                         k, s_valid, s_instr, s_pc, 32'h1000 + k, 10'(k));
            end
        end
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            advance();
            if (s_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid != 10) begin errors++; $display("FAIL start_throughput: got %0d valid cycles want 10", nvalid); end
    endtask

    task automatic test_backpressure();
        restart();
        instr_ready = 1'b0;
        repeat (3) advance();
        for (int i = 0; i < 5; i++) begin
            advance();
            checks++;
            if (s_rd !== 1'b0 || s_valid !== 1'b1 || s_instr !== 32'h1000 || s_pc !== 10'h0) begin
                errors++;
                $display("FAIL stall_hold%0d: got rd=%b v=%b instr=%h pc=%h want rd=0 v=1 instr=00001000 pc=000",
                         i, s_rd, s_valid, s_instr, s_pc);
            end
        end
        instr_ready = 1'b1;
        repeat (6) advance();
        checks++;
        if (obs_pc.size() < 3) begin
            errors++; $display("FAIL stall_release_count: got %0d deliveries want >=3", obs_pc.size());
        end else begin
            for (int k = 0; k < 3; k++)
                if (obs_pc[k] != k || obs_instr[k] !== 32'h1000 + k) begin
                    errors++;
                    $display("FAIL stall_release%0d: got pc=%h instr=%h want pc=%h instr=%h",
                             k, obs_pc[k], obs_instr[k], k, 32'h1000 + k);
                end
        end
    endtask

    task automatic test_redirect_flush();
        int n0;
        restart();
        instr_ready = 1'b1;
        repeat (8) advance();
        n0 = obs_pc.size();
        instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 10'h200;
        advance();
        redirect = 1'b0; instr_ready = 1'b1;
        advance();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_after: got %b want 0", s_valid); end
        checks++; if (s_rd !== 1'b1 || s_addr !== 10'h200) begin errors++; $display("FAIL flush_first_read: got rd=%b addr=%h want rd=1 addr=200", s_rd, s_addr); end
        repeat (6) advance();
        checks++;
        if (obs_pc.size() < n0 + 2) begin
            errors++; $display("FAIL flush_count: got %0d deliveries want >=%0d", obs_pc.size(), n0 + 2);
        end else if (obs_pc[n0] != 32'h200 || obs_pc[n0+1] != 32'h201 || obs_instr[n0] !== 32'h1200) begin
            errors++;
            $display("FAIL flush_stream: got pcs %h,%h instr %h want 200,201 instr 00001200",
                     obs_pc[n0], obs_pc[n0+1], obs_instr[n0]);
        end
    endtask

    task automatic test_redirect_handshake();
        logic [ADDR_W-1:0] rpc;
        int j, n4;
        restart();
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && !(instr_valid === 1'b1 && instr_pc === 10'd4); i++) advance();
        checks++;
        if (!(instr_valid === 1'b1 && instr_pc === 10'd4)) begin
            errors++; $display("FAIL hs_reach_pc4: got v=%b pc=%h want v=1 pc=004 within 20 cycles", instr_valid, instr_pc);
        end
        rpc = 10'($urandom_range(16, 1000));
        redirect = 1'b1; redirect_pc = rpc;
        advance();
        redirect = 1'b0;
        repeat (6) advance();
        n4 = 0; j = -1;
        foreach (obs_pc[i]) if (obs_pc[i] == 4) begin n4++; j = i; end
        checks++; if (n4 != 1) begin errors++; $display("FAIL hs_pc4_once: got %0d deliveries of pc 4 want 1", n4); end
        checks++;
        if (j < 0 || obs_pc.size() < j + 3) begin
            errors++; $display("FAIL hs_after_redirect: got %0d deliveries want pc 4 followed by two more", obs_pc.size());
        end else if (obs_pc[j+1] != int'(rpc) || obs_pc[j+2] != (int'(rpc) + 1) % 1024) begin
            errors++; $display("FAIL hs_after_redirect: got %h,%h want %h,%h", obs_pc[j+1], obs_pc[j+2], rpc, rpc + 10'd1);
        end
    endtask

    task automatic test_wrap();
        int n0;
        restart();
        instr_ready = 1'b1;
        repeat (5) advance();
        redirect = 1'b1; redirect_pc = 10'h3FF;
        advance();
        redirect = 1'b0;
        n0 = obs_pc.size();
        repeat (6) advance();
        checks++;
        if (obs_pc.size() < n0 + 3) begin
            errors++; $display("FAIL wrap_count: got %0d deliveries want >=%0d", obs_pc.size(), n0 + 3);
        end else if (obs_pc[n0] != 32'h3FF || obs_pc[n0+1] != 0 || obs_pc[n0+2] != 1 ||
                     obs_instr[n0] !== 32'h13FF || obs_instr[n0+1] !== 32'h1000) begin
            errors++;
            $display("FAIL wrap_stream: got pcs %h,%h,%h instr %h,%h want 3ff,000,001 instr 000013ff,00001000",
                     obs_pc[n0], obs_pc[n0+1], obs_pc[n0+2], obs_instr[n0], obs_instr[n0+1]);
        end
    endtask

    task automatic test_back_to_back();
        int n0, n100;
        restart();
        instr_ready = 1'b1;
        repeat (6) advance();
        redirect = 1'b1; redirect_pc = 10'h100;
        advance();
        redirect_pc = 10'h2A0;
        advance();
        redirect = 1'b0;
        n0 = obs_pc.size();
        repeat (6) advance();
        n100 = 0;
        foreach (obs_pc[i]) if (obs_pc[i] == 32'h100) n100++;
        checks++; if (n100 != 0) begin errors++; $display("FAIL b2b_first_target: got %0d deliveries of pc 100 want 0", n100); end
        checks++;
        if (obs_pc.size() < n0 + 2) begin
            errors++; $display("FAIL b2b_count: got %0d deliveries want >=%0d", obs_pc.size(), n0 + 2);
        end else if (obs_pc[n0] != 32'h2A0 || obs_pc[n0+1] != 32'h2A1) begin
            errors++; $display("FAIL b2b_stream: got %h,%h want 2a0,2a1", obs_pc[n0], obs_pc[n0+1]);
        end
    endtask

    task automatic test_async_reset();
        restart();
        instr_ready = 1'b0;
        repeat (6) advance();
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b want 1", s_valid); end
        reset = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || pm_rd !== 1'b0) begin errors++; $display("FAIL areset_immediate: got v=%b rd=%b want v=0 rd=0", instr_valid, pm_rd); end
        checks++; if (pm_addr !== RESET_PC || instr !== 32'h0 || instr_pc !== 10'h0) begin errors++; $display("FAIL areset_values: got addr=%h instr=%h pc=%h want %h,0,0", pm_addr, instr, instr_pc, RESET_PC); end
        advance();
        advance();
        obs_pc.delete(); obs_instr.delete(); ref_pc.delete();
        reset = 1'b1; instr_ready = 1'b1;
        repeat (6) advance();
        checks++;
        if (obs_pc.size() < 1 || obs_pc[0] != int'(RESET_PC) || obs_instr[0] !== 32'h1000) begin
            errors++; $display("FAIL areset_restart: got %0d deliveries, first pc=%h want first pc=%h instr 00001000",
                               obs_pc.size(), (obs_pc.size() > 0) ? obs_pc[0] : -1, RESET_PC);
        end
    endtask

    task automatic test_random();
        restart();
        for (int c = 0; c < 600; c++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 10'($urandom);
            advance();
        end
        redirect = 1'b0; instr_ready = 1'b1;
        repeat (4) advance();
        checks++; if (obs_pc.size() < 100) begin errors++; $display("FAIL rand_progress: got %0d deliveries want >=100", obs_pc.size()); end
        foreach (obs_pc[i]) begin
            checks++;
            if (obs_pc[i] != ref_pc[i] || obs_instr[i] !== 32'h1000 + ref_pc[i]) begin
                errors++;
                $display("FAIL rand_deliver%0d: got pc=%h instr=%h want pc=%h instr=%h",
                         i, obs_pc[i], obs_instr[i], ref_pc[i], 32'h1000 + ref_pc[i]);
            end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL protocol_rules: got %0d violations want 0", viol); end
    endtask

    initial begin
        checks = 0; errors = 0; viol = 0; ref_next = 0;
        reset = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0; pm_data = '0;
        prev_reset = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_redirect = 1'b0;
        prev_pc = '0; prev_instr = '0;
        @(negedge clk);
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_flush();
        test_redirect_handshake();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
